// File: rtl/count_ctrl_pkg.sv
// Shared types and default widths for the count_ctrl event-counting front end.
// The defaults match the downstream up counter.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CLR  = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } cc_state_t;

    localparam int CC_W  = 8;
    localparam int CC_N  = 10;
    localparam int CC_DB = 4;

endpackage

// File: rtl/evt_filter.sv
// Event conditioning: 2-flop synchronizer, optional debounce (COUNT_CTRL_DEBOUNCE_EN),
// and a registered rising-edge detector that emits a one-cycle rise strobe.
module evt_filter
    import count_ctrl_pkg::*;
#(
    parameter int db = CC_DB
) (
    input  logic clk,
    input  logic rst_b,
    input  logic evt,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic level_d;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= evt;
            sync_2 <= sync_1;
        end
    end

`ifdef COUNT_CTRL_DEBOUNCE_EN
    localparam int DB_W = (db < 1) ? 1 : $clog2(db + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(db - 1);

    logic [DB_W-1:0] db_cnt;

    // level follows sync_2 only after db consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            level  <= 1'b0;
            db_cnt <= '0;
        end else if (sync_2 != level) begin
            if (db_cnt == DB_LAST) begin
                level  <= sync_2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end
`else
    assign level = sync_2;

    // db has no effect without the filter; the reference keeps the parameter list uniform
    if (db < 1) begin : g_db_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            level_d <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_d <= level;
            rise    <= level & ~level_d;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// Run controller for the w-bit up counter: frames runs with clr, emits c_up per event,
// finishes after n events or on stop. Debounce is selected by COUNT_CTRL_DEBOUNCE_EN.
//
// state | meaning
// IDLE  | waiting for start (start=1, stop=0)
// CLR   | one-cycle clr pulse, ev_cnt cleared on exit
// RUN   | counting rises; once ev_cnt==n it waits one cycle so the last c_up precedes done
// DONE  | one-cycle done pulse, back to IDLE
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int w  = CC_W,
    parameter int n  = CC_N,
    parameter int db = CC_DB
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         start,
    input  logic         stop,
    input  logic         evt,
    output logic         c_up,
    output logic         clr,
    output logic         busy,
    output logic         done,
    output logic [w-1:0] ev_cnt
);

    localparam logic [w-1:0] N_LAST = w'(n);

    cc_state_t state;
    logic      rise;

    evt_filter #(
        .db(db)
    ) u_evt_filter (
        .clk  (clk),
        .rst_b(rst_b),
        .evt  (evt),
        .rise (rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state  <= IDLE;
            c_up   <= 1'b0;
            ev_cnt <= '0;
        end else begin
            c_up <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) state <= CLR;
                end
                CLR: begin
                    ev_cnt <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    // completion outranks a late stop: the n-th event is already counted
                    if (ev_cnt == N_LAST) begin
                        state <= DONE;
                    end else if (stop) begin
                        state <= IDLE;
                    end else if (rise) begin
                        c_up   <= 1'b1;
                        ev_cnt <= ev_cnt + w'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign clr  = (state == CLR);
    assign busy = (state == CLR) || (state == RUN);
    assign done = (state == DONE);

endmodule
